// File: rtl/flip_sched_pkg.sv
// -----------------------------------------------------------------------------
// flip_sched_pkg
// Shared types for the flip request scheduler.
//   IDX_W / ADDR_W : row/col index width and matrix base-address width
//   state_t        : scheduler FSM states
//   flip_req_t     : one queued rectangle-flip request
//   canon_req      : orders each index pair so that r1<=r2 and c1<=c2
//   is_degenerate  : true when the rectangle has zero height or width
// -----------------------------------------------------------------------------
package flip_sched_pkg;

  localparam int IDX_W  = 2;
  localparam int ADDR_W = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] base_addr;
    logic [IDX_W-1:0]  r1;
    logic [IDX_W-1:0]  r2;
    logic [IDX_W-1:0]  c1;
    logic [IDX_W-1:0]  c2;
    logic              last;
  } flip_req_t;

  function automatic flip_req_t canon_req(input flip_req_t r);
    flip_req_t o;
    o = r;
    if (r.r1 > r.r2) begin
      o.r1 = r.r2;
      o.r2 = r.r1;
    end else begin
      o.r1 = r.r1;
      o.r2 = r.r2;
    end
    if (r.c1 > r.c2) begin
      o.c1 = r.c2;
      o.c2 = r.c1;
    end else begin
      o.c1 = r.c1;
      o.c2 = r.c2;
    end
    return o;
  endfunction

  function automatic logic is_degenerate(input flip_req_t r);
    return (r.r1 == r.r2) || (r.c1 == r.c2);
  endfunction

endpackage

// File: rtl/flip_sched_if.sv
// -----------------------------------------------------------------------------
// flip_sched_if
// Request bus (host -> scheduler) and controller bus (scheduler <-> controller).
//   req_valid/req_ready        : request handshake
//   req_base_addr, req_r1..c2  : rectangle description, req_last closes a batch
//   fc_start                   : one-cycle start pulse to flip_controller
//   fc_base_addr, fc_r1..c2    : held from issue until the next issue
//   fc_done                    : sticky done level from the controller
// Modports: master = scheduler side, slave = host/controller side.
// -----------------------------------------------------------------------------
interface flip_sched_if;
  import flip_sched_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_base_addr;
  logic [IDX_W-1:0]  req_r1;
  logic [IDX_W-1:0]  req_r2;
  logic [IDX_W-1:0]  req_c1;
  logic [IDX_W-1:0]  req_c2;
  logic              req_last;

  logic              fc_start;
  logic [ADDR_W-1:0] fc_base_addr;
  logic [IDX_W-1:0]  fc_r1;
  logic [IDX_W-1:0]  fc_r2;
  logic [IDX_W-1:0]  fc_c1;
  logic [IDX_W-1:0]  fc_c2;
  logic              fc_done;

  modport master (
    input  req_valid, req_base_addr, req_r1, req_r2, req_c1, req_c2, req_last,
    output req_ready,
    output fc_start, fc_base_addr, fc_r1, fc_r2, fc_c1, fc_c2,
    input  fc_done
  );

  modport slave (
    output req_valid, req_base_addr, req_r1, req_r2, req_c1, req_c2, req_last,
    input  req_ready,
    input  fc_start, fc_base_addr, fc_r1, fc_r2, fc_c1, fc_c2,
    output fc_done
  );

endinterface

// File: rtl/flip_req_fifo.sv
// -----------------------------------------------------------------------------
// flip_req_fifo
// Synchronous FIFO of flip_req_t, DEPTH entries (power of two, >= 2).
//   clk, rst     : clock, asynchronous active-high reset (empties the FIFO)
//   push_i       : write wdata_i (ignored when full)
//   pop_i        : advance the read pointer (ignored when empty)
//   mark_last_i  : set the last flag of the youngest stored entry
//   rdata_o      : head entry (valid while !empty_o)
//   full_o, empty_o, count_o : occupancy from the registered count
// -----------------------------------------------------------------------------
module flip_req_fifo
  import flip_sched_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  flip_req_t              wdata_i,
  input  logic                   pop_i,
  input  logic                   mark_last_i,
  output flip_req_t              rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);

  flip_req_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] young_ptr_s;
  logic [PTR_W:0]   count_q;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full_o      = (count_q == (PTR_W+1)'(DEPTH));
  assign empty_o     = (count_q == (PTR_W+1)'(0));
  assign count_o     = count_q;
  assign push_ok_s   = push_i & ~full_o;
  assign pop_ok_s    = pop_i & ~empty_o;
  assign young_ptr_s = wr_ptr_q - PTR_W'(1);
  assign rdata_o     = mem_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok_s) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_ok_s)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage array; a mark never coincides with a push (the marking request is not stored).
  always_ff @(posedge clk) begin
    if (push_ok_s) mem_q[wr_ptr_q] <= wdata_i;
    if (mark_last_i & ~empty_o) mem_q[young_ptr_s].last <= 1'b1;
  end

endmodule

// File: rtl/flip_scheduler.sv
// -----------------------------------------------------------------------------
// flip_scheduler
// Queues rectangle-flip requests and issues them one at a time to
// flip_controller, counting completions and flagging end of batch.
//   clk, rst      : clock, asynchronous active-high reset
//   bus (master)  : request handshake in, controller start/done out/in
//   busy_o        : FIFO non-empty or a flip in flight
//   batch_done_o  : one-cycle pulse after the last-flagged flip completes
//   flip_cnt_o    : completed flips, saturating
//   drop_cnt_o    : discarded degenerate requests, saturating
// Optional feature macro: FLIP_SCHED_CANON_EN (index canonicalisation and
// dropping of zero-area rectangles). Undefined: requests stored verbatim and
// drop_cnt_o stays 0.
// -----------------------------------------------------------------------------
module flip_scheduler
  import flip_sched_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  flip_sched_if.master     bus,
  output logic             busy_o,
  output logic             batch_done_o,
  output logic [CNT_W-1:0] flip_cnt_o,
  output logic [CNT_W-1:0] drop_cnt_o
);

  localparam int FCNT_W = $clog2(DEPTH) + 1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  state_t            state_q, state_d;
  flip_req_t         in_req_s, store_req_s, head_s, pop_req_s, fc_req_q;
  logic              fifo_full_s, fifo_empty_s;
  logic [FCNT_W-1:0] fifo_count_s;
  logic              accept_s, push_s, pop_s, drop_s;
  logic              mark_fifo_s, mark_held_s, drop_batch_s;
  logic              done_q, done_rise_s, complete_s;
  logic              fc_start_q, batch_done_q;
  logic [CNT_W-1:0]  flip_cnt_q, drop_cnt_q;

  assign in_req_s = '{base_addr: bus.req_base_addr, r1: bus.req_r1, r2: bus.req_r2,
                      c1: bus.req_c1, c2: bus.req_c2, last: bus.req_last};

  // Ready comes from the registered count only: a pop this cycle does not open a slot.
  assign bus.req_ready = ~fifo_full_s & ~rst;
  assign accept_s      = bus.req_valid & ~fifo_full_s;
  assign pop_s         = (state_q == S_IDLE) & ~fifo_empty_s;
  // A stale high done level never counts; only a 0->1 transition does.
  assign done_rise_s   = bus.fc_done & ~done_q;
  assign complete_s    = (state_q == S_WAIT) & done_rise_s;

`ifdef FLIP_SCHED_CANON_EN
  logic degen_s, flight_s;

  assign degen_s     = is_degenerate(in_req_s);
  assign store_req_s = canon_req(in_req_s);
  assign push_s      = accept_s & ~degen_s;
  assign drop_s      = accept_s & degen_s;
  // A flip finishing this very cycle is no longer a carrier for a moved last flag.
  assign flight_s    = (state_q == S_ISSUE) | ((state_q == S_WAIT) & ~done_rise_s);

  // Relocate the last flag of a dropped request to the youngest surviving flip.
  always_comb begin
    mark_fifo_s  = 1'b0;
    mark_held_s  = 1'b0;
    drop_batch_s = 1'b0;
    if (drop_s & in_req_s.last) begin
      if (pop_s & (fifo_count_s == FCNT_W'(1))) begin
        mark_held_s = 1'b1;        // sole entry is leaving for the fc_* regs now
      end else if (~fifo_empty_s) begin
        mark_fifo_s = 1'b1;
      end else if (flight_s) begin
        mark_held_s = 1'b1;
      end else begin
        drop_batch_s = 1'b1;       // nothing outstanding: batch ends right away
      end
    end else begin
      mark_fifo_s  = 1'b0;
      mark_held_s  = 1'b0;
      drop_batch_s = 1'b0;
    end
  end
`else
  logic unused_count_s;

  assign unused_count_s = ^fifo_count_s;
  assign store_req_s    = in_req_s;
  assign push_s         = accept_s;
  assign drop_s         = 1'b0;
  assign mark_fifo_s    = 1'b0;
  assign mark_held_s    = 1'b0;
  assign drop_batch_s   = 1'b0;
`endif

  flip_req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push_s),
    .wdata_i     (store_req_s),
    .pop_i       (pop_s),
    .mark_last_i (mark_fifo_s),
    .rdata_o     (head_s),
    .full_o      (fifo_full_s),
    .empty_o     (fifo_empty_s),
    .count_o     (fifo_count_s)
  );

  // Head entry as latched at issue, with any last flag moved onto it this cycle.
  always_comb begin
    pop_req_s      = head_s;
    pop_req_s.last = head_s.last | mark_held_s;
  end

  // Scheduler next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (~fifo_empty_s) state_d = S_ISSUE;
        else               state_d = S_IDLE;
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (done_rise_s) state_d = S_GAP;
        else             state_d = S_WAIT;
      end
      S_GAP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State, held request, start/batch pulses and saturating counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      done_q       <= 1'b1;
      fc_req_q     <= '0;
      fc_start_q   <= 1'b0;
      batch_done_q <= 1'b0;
      flip_cnt_q   <= '0;
      drop_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      done_q       <= bus.fc_done;
      fc_start_q   <= pop_s;
      batch_done_q <= (complete_s & fc_req_q.last) | drop_batch_s;
      if (pop_s)            fc_req_q      <= pop_req_s;
      else if (mark_held_s) fc_req_q.last <= 1'b1;
      if (complete_s) flip_cnt_q <= sat_inc(flip_cnt_q);
      if (drop_s)     drop_cnt_q <= sat_inc(drop_cnt_q);
    end
  end

  assign bus.fc_start     = fc_start_q;
  assign bus.fc_base_addr = fc_req_q.base_addr;
  assign bus.fc_r1        = fc_req_q.r1;
  assign bus.fc_r2        = fc_req_q.r2;
  assign bus.fc_c1        = fc_req_q.c1;
  assign bus.fc_c2        = fc_req_q.c2;
  assign busy_o           = ~fifo_empty_s | (state_q != S_IDLE);
  assign batch_done_o     = batch_done_q;
  assign flip_cnt_o       = flip_cnt_q;
  assign drop_cnt_o       = drop_cnt_q;

endmodule

// File: tb/tb_flip_scheduler.sv
// -----------------------------------------------------------------------------
// tb_flip_scheduler
// Random and directed requests against a timeline reference model. A second
// instance with 2-bit counters mirrors the first one's inputs so that counter
// saturation is reached within a short run.
// -----------------------------------------------------------------------------
module tb_flip_scheduler;
  import flip_sched_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = 16;
`ifdef FLIP_SCHED_CANON_EN
  localparam bit CANON = 1'b1;
`else
  localparam bit CANON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  flip_sched_if bus_a ();
  flip_sched_if bus_b ();

  logic             busy_a, bd_a, busy_b, bd_b;
  logic [CNT_W-1:0] fcnt_a, dcnt_a;
  logic [1:0]       fcnt_b, dcnt_b;

  flip_scheduler #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .bus(bus_a.master),
    .busy_o(busy_a), .batch_done_o(bd_a), .flip_cnt_o(fcnt_a), .drop_cnt_o(dcnt_a)
  );

  flip_scheduler #(.DEPTH(DEPTH), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .bus(bus_b.master),
    .busy_o(busy_b), .batch_done_o(bd_b), .flip_cnt_o(fcnt_b), .drop_cnt_o(dcnt_b)
  );

  // Stimulus and controller-model drivers
  logic      stim_valid = 1'b0;
  flip_req_t stim_req   = '0;
  logic      ctl_done   = 1'b1;

  assign bus_a.req_valid     = stim_valid;
  assign bus_a.req_base_addr = stim_req.base_addr;
  assign bus_a.req_r1        = stim_req.r1;
  assign bus_a.req_r2        = stim_req.r2;
  assign bus_a.req_c1        = stim_req.c1;
  assign bus_a.req_c2        = stim_req.c2;
  assign bus_a.req_last      = stim_req.last;
  assign bus_a.fc_done       = ctl_done;
  assign bus_b.req_valid     = stim_valid;
  assign bus_b.req_base_addr = stim_req.base_addr;
  assign bus_b.req_r1        = stim_req.r1;
  assign bus_b.req_r2        = stim_req.r2;
  assign bus_b.req_c1        = stim_req.c1;
  assign bus_b.req_c2        = stim_req.c2;
  assign bus_b.req_last      = stim_req.last;
  assign bus_b.fc_done       = ctl_done;

  int n_errors = 0;
  int n_checks = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      if (n_errors <= 30)
        $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  function automatic int sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  function automatic flip_req_t mk(input logic [7:0] a, input logic [1:0] r1, input logic [1:0] r2,
                                   input logic [1:0] c1, input logic [1:0] c2, input logic last);
    flip_req_t r;
    r.base_addr = a; r.r1 = r1; r.r2 = r2; r.c1 = c1; r.c2 = c2; r.last = last;
    return r;
  endfunction

  // ---------------- controller model: done falls lo cycles after start, rises hi later
  bit ctl_rand = 1'b0;
  int ctl_lo = 0, ctl_hi = 0;
  bit ctl_act = 1'b0;
  initial forever begin
    @(negedge clk);
    if (bus_a.fc_start) begin
      ctl_lo  = ctl_rand ? $urandom_range(4, 1) : 3;
      ctl_hi  = ctl_lo + (ctl_rand ? $urandom_range(12, 1) : 10);
      ctl_act = 1'b1;
    end else if (ctl_act) begin
      ctl_lo--; ctl_hi--;
      if (ctl_lo == 0) ctl_done = 1'b0;
      if (ctl_hi == 0) begin ctl_done = 1'b1; ctl_act = 1'b0; end
    end
  end

  // ---------------- reference model: timeline of pushes, issues and completions
  flip_req_t qm[$];
  flip_req_t m_cur = '0;
  bit m_inflight = 1'b0, m_prev_done = 1'b1, m_start = 1'b0, m_batch = 1'b0;
  bit m_busy = 1'b0, m_ready = 1'b0;
  int m_issue = 0, m_free = 0, m_cnt = 0, m_drop = 0, n_edge = 0;

  task automatic model_step();
    flip_req_t r, t;
    bit rise;
    int pre;
    n_edge++;
    if (rst) begin
      qm.delete(); m_cur = '0; m_inflight = 1'b0; m_prev_done = 1'b1;
      m_start = 1'b0; m_batch = 1'b0; m_cnt = 0; m_drop = 0; m_free = 0;
    end else begin
      rise = bus_a.fc_done && !m_prev_done;
      m_prev_done = bus_a.fc_done;
      m_start = 1'b0; m_batch = 1'b0;
      pre = qm.size();
      if (m_inflight && n_edge >= m_issue + 2 && rise) begin
        m_cnt++;
        if (m_cur.last) m_batch = 1'b1;
        m_inflight = 1'b0;
        m_free = n_edge + 2;
      end else if (!m_inflight && n_edge >= m_free && pre > 0) begin
        m_cur = qm.pop_front();
        m_inflight = 1'b1; m_issue = n_edge; m_start = 1'b1;
      end
      if (stim_valid && pre < DEPTH) begin
        r = stim_req;
        if (CANON && (r.r1 == r.r2 || r.c1 == r.c2)) begin
          m_drop++;
          if (r.last) begin
            if (qm.size() > 0) begin
              t = qm[qm.size()-1]; t.last = 1'b1; qm[qm.size()-1] = t;
            end else if (m_inflight) m_cur.last = 1'b1;
            else m_batch = 1'b1;
          end
        end else begin
          if (CANON) r = mk(r.base_addr, (r.r1 < r.r2) ? r.r1 : r.r2, (r.r1 < r.r2) ? r.r2 : r.r1,
                            (r.c1 < r.c2) ? r.c1 : r.c2, (r.c1 < r.c2) ? r.c2 : r.c1, r.last);
          qm.push_back(r);
        end
      end
    end
    m_busy  = (qm.size() > 0) || m_inflight || (n_edge + 1 < m_free);
    m_ready = !rst && (qm.size() < DEPTH);
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // ---------------- output comparison, half a cycle after each active edge
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("fc_start",   bus_a.fc_start,     m_start);
      check("req_ready",  bus_a.req_ready,    m_ready);
      check("busy",       busy_a,             m_busy);
      check("batch_done", bd_a,               m_batch);
      check("flip_cnt",   fcnt_a,             sat(m_cnt, 65535));
      check("drop_cnt",   dcnt_a,             sat(m_drop, 65535));
      check("fc_base",    bus_a.fc_base_addr, m_cur.base_addr);
      check("fc_rows",    {bus_a.fc_r1, bus_a.fc_r2}, {m_cur.r1, m_cur.r2});
      check("fc_cols",    {bus_a.fc_c1, bus_a.fc_c2}, {m_cur.c1, m_cur.c2});
      check("sat_start",  bus_b.fc_start,     m_start);
      check("sat_flip",   fcnt_b,             sat(m_cnt, 3));
      check("sat_drop",   dcnt_b,             sat(m_drop, 3));
    end
  end

  // ---------------- stimulus helpers
  task automatic do_push(input flip_req_t r);
    bit rdy, done;
    done = 1'b0;
    @(negedge clk); #1;
    stim_valid = 1'b1; stim_req = r;
    for (int k = 0; k < 300 && !done; k++) begin
      rdy = bus_a.req_ready;
      @(posedge clk);
      if (rdy) done = 1'b1;
      else begin @(negedge clk); #1; end
    end
    check("push_accept", {31'd0, rdy}, 32'd1);
  endtask

  task automatic idle(input int n);
    @(negedge clk); #1;
    stim_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(negedge clk); #1;
    rst = 1'b1;
    @(negedge clk); #1;
    rst = 1'b0;
  endtask

  // ---------------- test sequence
  initial begin
    flip_req_t r;
    @(posedge clk); #1;
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;

    // single request issued with done already high from before reset
    do_push(mk(8'h10, 2'd0, 2'd2, 2'd1, 2'd3, 1'b1));
    idle(40);

    // five back-to-back requests against a four-entry FIFO
    for (int i = 0; i < 5; i++)
      do_push(mk(8'h20 + 8'(i), 2'd0, 2'd1, 2'd2, 2'd3, (i == 4)));
    idle(120);

    // reset while the flip waits for done
    do_push(mk(8'h40, 2'd1, 2'd3, 2'd0, 2'd2, 1'b1));
    idle(6);
    pulse_reset();
    idle(30);

    // reversed index pairs, then a zero-height last-flagged request
    do_push(mk(8'h30, 2'd3, 2'd1, 2'd2, 2'd0, 1'b0));
    idle(30);
    do_push(mk(8'h31, 2'd2, 2'd2, 2'd1, 2'd3, 1'b1));
    idle(30);

    // randomized traffic with a randomized controller
    ctl_rand = 1'b1;
    for (int i = 0; i < 70; i++) begin
      r.base_addr = 8'($urandom);
      r.r1 = 2'($urandom); r.r2 = 2'($urandom);
      r.c1 = 2'($urandom); r.c2 = 2'($urandom);
      r.last = ($urandom_range(3, 0) == 0);
      do_push(r);
      if ($urandom_range(3, 0) == 0) idle($urandom_range(25, 1));
    end
    idle(1);
    for (int k = 0; k < 3000 && busy_a; k++) @(negedge clk);
    check("drain_busy", {31'd0, busy_a}, 32'd0);
    idle(20);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
